// File: rtl/ps2_kbd_tx_pkg.sv
// Shared types and constants for the PS/2 keyboard transmitter slice.
// Frame layout, serialiser states and the odd-parity helper live here.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_LAST_BIT   = 10;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    GAP
  } ps2_state_e;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Scancode valid/ready port of ps2_kbd_tx.
// PS2_KBD_PARITY_INJ_EN adds a per-byte parity-error injection flag.
interface ps2_kbd_tx_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
`ifdef PS2_KBD_PARITY_INJ_EN
  logic       in_perr;
`endif

`ifdef PS2_KBD_PARITY_INJ_EN
  modport master (output in_valid, output in_data, output in_perr, input in_ready);
  modport slave  (input in_valid, input in_data, input in_perr, output in_ready);
`else
  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
`endif

endinterface

// File: rtl/ps2_kbd_tx_fifo.sv
// Small synchronous FIFO buffering scancodes ahead of the serialiser.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module ps2_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-to-host keyboard transmitter: FIFO plus 11-bit frame serialiser.
// Optional macro PS2_KBD_PARITY_INJ_EN: per-byte flag inverting the sent parity bit.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int HALF_DIV   = 8,
  parameter int GAP_CYCLES = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  ps2_kbd_tx_if.slave                   in_if,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX = (HALF_DIV > GAP_CYCLES) ? HALF_DIV : GAP_CYCLES;
  localparam int DW      = $clog2(CNT_MAX + 1);
`ifdef PS2_KBD_PARITY_INJ_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif

  ps2_state_e                state_q, state_d;
  logic [DW-1:0]             div_q, div_d;
  logic [3:0]                bit_idx_q, bit_idx_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      ps2_clk_q, ps2_clk_d;
  logic                      ps2_data_q, ps2_data_d;
  logic                      busy_q, busy_d;

  logic          in_ready;
  logic          push;
  logic          pop;
  logic [FW-1:0] push_data;
  logic [FW-1:0] head;
  logic          parity;

  // Ready comes from the registered count only, and is held low during reset.
  assign in_ready       = ~reset & (fifo_count != CW'(FIFO_DEPTH));
  assign in_if.in_ready = in_ready;
  assign push           = in_if.in_valid & in_ready;

`ifdef PS2_KBD_PARITY_INJ_EN
  assign push_data = {in_if.in_perr, in_if.in_data};
  assign parity    = odd_parity(head[7:0]) ^ head[8];
`else
  assign push_data = in_if.in_data;
  assign parity    = odd_parity(head);
`endif

  ps2_tx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          frame_d   = {1'b1, parity, head[7:0], 1'b0};
          bit_idx_d = '0;
          div_d     = '0;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (div_q == DW'(HALF_DIV - 1)) begin
          div_d   = '0;
          state_d = LOW;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LOW: begin
        if (div_q == DW'(HALF_DIV - 1)) begin
          div_d = '0;
          if (bit_idx_q == 4'(PS2_LAST_BIT)) begin
            state_d = GAP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = HIGH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_q == DW'(GAP_CYCLES - 1)) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drivers are registered from the current state so the pins are glitch-free.
  always_comb begin
    ps2_clk_d  = (state_q != LOW);
    ps2_data_d = 1'b1;
    busy_d     = (state_q != IDLE);
    if (state_q == HIGH || state_q == LOW) begin
      ps2_data_d = frame_q[bit_idx_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
    end
  end

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed-vector bench for ps2_kbd_tx with a PS/2 frame capture model.
// Build with PS2_KBD_PARITY_INJ_EN to also exercise parity injection.
module tb_ps2_kbd_tx;

  localparam int HALF_DIV   = 8;
  localparam int GAP_CYCLES = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int PERIOD     = 22 * HALF_DIV + GAP_CYCLES + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [3:0] fifo_count;

  ps2_kbd_tx_if in_if ();

  ps2_kbd_tx #(
    .HALF_DIV   (HALF_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_if      (in_if),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Receiver model: samples data on each falling ps2_clk edge, LSB first.
  logic [10:0] rx_sh = '0;
  int          rx_cnt = 0;
  int          fall_cnt = 0;
  logic [10:0] rx_q[$];
  int          rx_start[$];

  always @(negedge ps2_clk) begin
    if (rx_cnt == 0) rx_start.push_back(cyc);
    rx_sh = {ps2_data, rx_sh[10:1]};
    rx_cnt++;
    fall_cnt++;
    if (rx_cnt == 11) begin
      rx_q.push_back(rx_sh);
      rx_cnt = 0;
    end
  end

  always @(posedge clock) begin
    if (reset) rx_cnt = 0;
  end

  task automatic push_byte(input logic [7:0] b);
    in_if.in_valid = 1'b1;
    in_if.in_data  = b;
`ifdef PS2_KBD_PARITY_INJ_EN
    in_if.in_perr  = 1'b0;
`endif
    @(negedge clock);
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int nframes, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (rx_q.size() >= nframes && !busy && fifo_count == 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_data  = 8'h00;
`ifdef PS2_KBD_PARITY_INJ_EN
    in_if.in_perr  = 1'b0;
`endif
    repeat (3) @(negedge clock);
    vec_cnt++;
    if (in_if.in_ready !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_if.in_ready);
    end
    vec_cnt++;
    if (ps2_clk !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL reset_ps2_clk: got %b want 1", ps2_clk);
    end
    vec_cnt++;
    if (ps2_data !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL reset_ps2_data: got %b want 1", ps2_data);
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
    vec_cnt++;
    if (fifo_count !== 4'd0) begin
      err_cnt++; $display("[TB] FAIL reset_fifo_count: got %0d want 0", fifo_count);
    end
    reset = 1'b0;
    @(negedge clock);
    vec_cnt++;
    if (in_if.in_ready !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL release_in_ready: got %b want 1", in_if.in_ready);
    end
  endtask

  task automatic test_single_frame();
    int first_fall;
    int busy_cycles;
    rx_q.delete();
    rx_start.delete();
    first_fall  = -1;
    busy_cycles = 0;
    push_byte(8'h1C);
    for (int n = 0; n < 300; n++) begin
      if (ps2_clk === 1'b0 && first_fall < 0) first_fall = n;
      if (busy === 1'b1) busy_cycles++;
      @(negedge clock);
    end
    vec_cnt++;
    if (first_fall !== 10) begin
      err_cnt++; $display("[TB] FAIL first_fall_latency: got %0d want 10", first_fall);
    end
    vec_cnt++;
    if (busy_cycles !== 192) begin
      err_cnt++; $display("[TB] FAIL busy_duration: got %0d want 192", busy_cycles);
    end
    vec_cnt++;
    if (rx_q.size() !== 1) begin
      err_cnt++; $display("[TB] FAIL single_frame_count: got %0d want 1", rx_q.size());
    end else begin
      vec_cnt++;
      if (rx_q[0] !== 11'b10000111000) begin
        err_cnt++; $display("[TB] FAIL frame_1C: got %b want 10000111000", rx_q[0]);
      end
    end
    vec_cnt++;
    if ({ps2_clk, ps2_data, busy} !== 3'b110) begin
      err_cnt++; $display("[TB] FAIL idle_lines: got %b want 110", {ps2_clk, ps2_data, busy});
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rx_q.delete();
    rx_start.delete();
    push_byte(8'hF0);
    push_byte(8'h1C);
    wait_done(2, 1000, ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++; $display("[TB] FAIL b2b_timeout: got %0d frames want 2", rx_q.size());
    end
    vec_cnt++;
    if (rx_q.size() !== 2) begin
      err_cnt++; $display("[TB] FAIL b2b_frame_count: got %0d want 2", rx_q.size());
    end else begin
      vec_cnt++;
      if (rx_q[0] !== 11'b11111100000) begin
        err_cnt++; $display("[TB] FAIL frame_F0: got %b want 11111100000", rx_q[0]);
      end
      vec_cnt++;
      if (rx_q[1] !== 11'b10000111000) begin
        err_cnt++; $display("[TB] FAIL frame_1C_second: got %b want 10000111000", rx_q[1]);
      end
      vec_cnt++;
      if (rx_start[1] - rx_start[0] !== PERIOD) begin
        err_cnt++; $display("[TB] FAIL frame_period: got %0d want %0d", rx_start[1] - rx_start[0], PERIOD);
      end
    end
  endtask

  task automatic test_parity_extremes();
    bit ok;
    rx_q.delete();
    rx_start.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_done(2, 1000, ok);
    vec_cnt++;
    if (!ok || rx_q.size() !== 2) begin
      err_cnt++; $display("[TB] FAIL extremes_frame_count: got %0d want 2", rx_q.size());
    end else begin
      vec_cnt++;
      if (rx_q[0] !== 11'b11000000000) begin
        err_cnt++; $display("[TB] FAIL frame_00: got %b want 11000000000", rx_q[0]);
      end
      vec_cnt++;
      if (rx_q[1] !== 11'b11111111110) begin
        err_cnt++; $display("[TB] FAIL frame_FF: got %b want 11111111110", rx_q[1]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0]  bytes [9] = '{8'h01, 8'h22, 8'h07, 8'h44, 8'h1F, 8'h66, 8'h7F, 8'h88, 8'h99};
    logic        par   [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [10:0] want;
    int          i;
    int          guard;
    logic        rdy;
    bit          ok;
    rx_q.delete();
    rx_start.delete();
    i     = 0;
    guard = 0;
    in_if.in_valid = 1'b1;
    while (i < 9 && guard < 50) begin
      in_if.in_data = bytes[i];
      rdy = in_if.in_ready;
      @(negedge clock);
      if (rdy) i++;
      guard++;
    end
    vec_cnt++;
    if (i !== 9) begin
      err_cnt++; $display("[TB] FAIL full_push_progress: got %0d want 9", i);
    end
    in_if.in_data = 8'hEE;
    vec_cnt++;
    if (fifo_count !== 4'd8) begin
      err_cnt++; $display("[TB] FAIL full_count: got %0d want 8", fifo_count);
    end
    vec_cnt++;
    if (in_if.in_ready !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL full_in_ready: got %b want 0", in_if.in_ready);
    end
    repeat (5) @(negedge clock);
    in_if.in_valid = 1'b0;
    vec_cnt++;
    if (fifo_count !== 4'd8) begin
      err_cnt++; $display("[TB] FAIL full_no_overflow: got %0d want 8", fifo_count);
    end
    wait_done(9, 3000, ok);
    vec_cnt++;
    if (!ok || rx_q.size() !== 9) begin
      err_cnt++; $display("[TB] FAIL full_frame_count: got %0d want 9", rx_q.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        want = {1'b1, par[k], bytes[k], 1'b0};
        vec_cnt++;
        if (rx_q[k] !== want) begin
          err_cnt++; $display("[TB] FAIL full_frame_%0d: got %b want %b", k, rx_q[k], want);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int guard;
    int falls_before;
    rx_q.delete();
    rx_start.delete();
    push_byte(8'hAA);
    push_byte(8'h55);
    guard = 0;
    while (rx_cnt < 5 && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    vec_cnt++;
    if (rx_cnt !== 5) begin
      err_cnt++; $display("[TB] FAIL midframe_reach_bit5: got %0d want 5", rx_cnt);
    end
    repeat (HALF_DIV + 2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vec_cnt++;
    if ({ps2_clk, ps2_data} !== 2'b11) begin
      err_cnt++; $display("[TB] FAIL midreset_lines: got %b want 11", {ps2_clk, ps2_data});
    end
    vec_cnt++;
    if (fifo_count !== 4'd0) begin
      err_cnt++; $display("[TB] FAIL midreset_fifo_count: got %0d want 0", fifo_count);
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL midreset_busy: got %b want 0", busy);
    end
    reset = 1'b0;
    falls_before = fall_cnt;
    @(negedge clock);
    vec_cnt++;
    if (in_if.in_ready !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL midreset_in_ready: got %b want 1", in_if.in_ready);
    end
    repeat (500) @(negedge clock);
    vec_cnt++;
    if (fall_cnt !== falls_before) begin
      err_cnt++; $display("[TB] FAIL midreset_no_edges: got %0d want %0d", fall_cnt, falls_before);
    end
    vec_cnt++;
    if ({busy, fifo_count} !== 5'b0_0000) begin
      err_cnt++; $display("[TB] FAIL midreset_quiet: got busy=%b count=%0d want 0/0", busy, fifo_count);
    end
  endtask

`ifdef PS2_KBD_PARITY_INJ_EN
  task automatic test_parity_inj();
    bit ok;
    rx_q.delete();
    rx_start.delete();
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'h1C;
    in_if.in_perr  = 1'b1;
    @(negedge clock);
    in_if.in_data  = 8'h32;
    in_if.in_perr  = 1'b0;
    @(negedge clock);
    in_if.in_valid = 1'b0;
    wait_done(2, 1000, ok);
    vec_cnt++;
    if (!ok || rx_q.size() !== 2) begin
      err_cnt++; $display("[TB] FAIL perr_frame_count: got %0d want 2", rx_q.size());
    end else begin
      vec_cnt++;
      if (rx_q[0] !== 11'b11000111000) begin
        err_cnt++; $display("[TB] FAIL perr_frame_1C: got %b want 11000111000", rx_q[0]);
      end
      vec_cnt++;
      if (rx_q[1] !== 11'b10001100100) begin
        err_cnt++; $display("[TB] FAIL perr_frame_32: got %b want 10001100100", rx_q[1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_extremes();
    test_fifo_full();
    test_reset_midframe();
`ifdef PS2_KBD_PARITY_INJ_EN
    test_parity_inj();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
